riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu.sv | 128 ++++++++++++
 tb/tb_riscv_lsu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// Load/store unit between a RISC-V core and a single-beat word-addressed memory.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into bus errors.
module riscv_lsu #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic        dbg_state_o
);

    // Handshake: a request is held with core_req_i=1 while core_stall_o=1; the
    // access ends in the cycle the stall drops (completion, timeout or abort).
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        is_byte, is_half, is_word, is_signed;
    logic        abort, timeout, done;
    logic        req_c, stall_c, err_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [3:0]  be_c;
    logic [31:0] wd_c;

    assign is_byte   = (core_size_i == 3'd0) || (core_size_i == 3'd4);
    assign is_half   = (core_size_i == 3'd1) || (core_size_i == 3'd5);
    assign is_word   = ~is_byte & ~is_half;
    assign is_signed = ~core_size_i[2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign abort = (state_q == IDLE) && core_req_i &&
                   ((is_half && core_addr_i[0]) || (is_word && (core_addr_i[1:0] != 2'b00)));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        err_c   = 1'b0;
        timeout = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                req_c   = core_req_i & ~abort;
                stall_c = core_req_i & ~abort;
                err_c   = abort;
                if (core_req_i && !abort) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                req_c   = 1'b1;
                timeout = ~mem_ready_i && (cnt_q == CNT_LAST);
                done    = mem_ready_i;
                stall_c = core_req_i & ~(mem_ready_i | timeout);
                err_c   = timeout;
                if (mem_ready_i || timeout) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane select for loads; store data is replicated so any lane carries it.
    assign ld_byte = mem_rd_i[{core_addr_i[1:0], 3'b000} +: 8];
    assign ld_half = mem_rd_i[{core_addr_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = mem_rd_i;
        be_c   = 4'b1111;
        wd_c   = core_wd_i;
        if (is_byte) begin
            ld_ext = {{24{is_signed & ld_byte[7]}}, ld_byte};
            be_c   = 4'b0001 << core_addr_i[1:0];
            wd_c   = {4{core_wd_i[7:0]}};
        end else if (is_half) begin
            ld_ext = {{16{is_signed & ld_half[15]}}, ld_half};
            be_c   = 4'b0011 << {core_addr_i[1], 1'b0};
            wd_c   = {2{core_wd_i[15:0]}};
        end
    end

    assign core_rd_o    = (rst_i && done && !core_we_i) ? ld_ext : 32'h0;
    assign core_stall_o = rst_i & stall_c;
    assign bus_err_o    = rst_i & err_c;
    assign mem_req_o    = rst_i & req_c;
    assign mem_we_o     = rst_i & req_c & core_we_i;
    assign mem_be_o     = rst_i ? be_c : 4'b0000;
    assign mem_addr_o   = rst_i ? {core_addr_i[31:2], 2'b00} : 32'h0;
    assign mem_wd_o     = rst_i ? wd_c : 32'h0;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu (TIMEOUT=4): scoreboard of expected load results.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'h0;
    logic [31:0] core_wd_i = 32'h0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = 32'h0;
    logic        mem_ready_i = 1'b0;
    logic        dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    riscv_lsu #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .bus_err_o(bus_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i), .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] model_rd(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> (8 * addr[1:0]);
        case (size)
            3'd0: model_rd = 32'($signed(sh[7:0]));
            3'd4: model_rd = {24'h0, sh[7:0]};
            3'd1: model_rd = 32'($signed(sh[15:0]));
            3'd5: model_rd = {16'h0, sh[15:0]};
            default: model_rd = word;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] size, input logic [1:0] a);
        if (size == 3'd0 || size == 3'd4) model_be = 4'b0001 << a;
        else if (size == 3'd1 || size == 3'd5) model_be = a[1] ? 4'b1100 : 4'b0011;
        else model_be = 4'b1111;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] size, input logic [31:0] wd);
        if (size == 3'd0 || size == 3'd4) model_wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        else if (size == 3'd1 || size == 3'd5) model_wd = {wd[15:0], wd[15:0]};
        else model_wd = wd;
    endfunction

    // Called just after a rising edge; delay >= 1 is the WAIT cycle that sees ready.
    task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] word, input int delay,
                             input string name);
        logic [31:0] exp_rd;
        exp_q.push_back(we ? 32'h0 : model_rd(size, addr, word));
        core_req_i = 1'b1; core_we_i = we; core_size_i = size;
        core_addr_i = addr; core_wd_i = wd; mem_rd_i = word;
        for (int k = 0; k <= delay; k++) begin
            mem_ready_i = (k == delay) ? 1'b1 : ((k == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            @(negedge clk_i);
            n_cmp++;
            if (core_stall_o !== (k < delay)) begin
                n_err++; $display("FAIL %s stall k=%0d got %b exp %b", name, k, core_stall_o, k < delay);
            end
            n_cmp++;
            if (mem_req_o !== 1'b1 || mem_we_o !== we || bus_err_o !== 1'b0) begin
                n_err++; $display("FAIL %s req/we/err k=%0d got %b%b%b exp 1%b0", name, k, mem_req_o, mem_we_o, bus_err_o, we);
            end
            n_cmp++;
            if (mem_addr_o !== {addr[31:2], 2'b00} || mem_be_o !== model_be(size, addr[1:0])) begin
                n_err++; $display("FAIL %s addr/be got %h/%b exp %h/%b", name, mem_addr_o, mem_be_o, {addr[31:2], 2'b00}, model_be(size, addr[1:0]));
            end
            if (we) begin
                n_cmp++;
                if (mem_wd_o !== model_wd(size, wd)) begin
                    n_err++; $display("FAIL %s wd got %h exp %h", name, mem_wd_o, model_wd(size, wd));
                end
            end
            exp_rd = 32'h0;
            if (k == delay) exp_rd = exp_q.pop_front();
            n_cmp++;
            if (core_rd_o !== exp_rd) begin
                n_err++; $display("FAIL %s rd k=%0d got %h exp %h", name, k, core_rd_o, exp_rd);
            end
            @(posedge clk_i); #1;
        end
        mem_ready_i = 1'b0;
    endtask

    task automatic idle_cycle();
        core_req_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'h1234_5678; core_wd_i = 32'hDEAD_BEEF; mem_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #2;
        n_cmp++;
        if ({core_rd_o, core_stall_o, bus_err_o, mem_req_o, mem_we_o} !== 36'h0) begin
            n_err++; $display("FAIL reset ctl got %h/%b%b%b%b exp 0", core_rd_o, core_stall_o, bus_err_o, mem_req_o, mem_we_o);
        end
        n_cmp++;
        if (mem_be_o !== 4'h0 || mem_addr_o !== 32'h0 || mem_wd_o !== 32'h0 || dbg_state_o !== 1'b0) begin
            n_err++; $display("FAIL reset data got %b/%h/%h/%b exp 0", mem_be_o, mem_addr_o, mem_wd_o, dbg_state_o);
        end
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        // First request right after release must be accepted.
        do_access(1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1, "first_lw");
        idle_cycle();
    endtask

    task automatic test_spec_vectors();
        do_access(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, "lb_0x103");
        idle_cycle();
        do_access(1'b1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, "sh_0x202");
        idle_cycle();
        do_access(1'b0, 3'd5, 32'h0000_0002, 32'h0, 32'h9876_5432, 2, "lhu_0x2");
        idle_cycle();
        do_access(1'b0, 3'd1, 32'h0000_0002, 32'h0, 32'h9876_5432, 1, "lh_0x2");
        do_access(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, "lbu_0x103");
        idle_cycle();
    endtask

    task automatic test_random();
        logic [2:0]  size;
        logic [31:0] addr;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0: size = 3'd0; 1: size = 3'd1; 2: size = 3'd2; 3: size = 3'd4;
                4: size = 3'd5; 5: size = 3'd3; 6: size = 3'd6; default: size = 3'd7;
            endcase
            addr = $urandom;
            if (size == 3'd1 || size == 3'd5) addr[0] = 1'b0;
            else if (!(size == 3'd0 || size == 3'd4)) addr[1:0] = 2'b00;
            do_access(1'($urandom_range(0, 1)), size, addr, $urandom, $urandom,
                      $urandom_range(1, 3), "random");
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 3'd2, 32'h0000_0020, 32'h0, 32'h1111_2222, 1, "b2b_0");
        do_access(1'b1, 3'd0, 32'h0000_0021, 32'h0000_00A5, 32'h0, 1, "b2b_1");
        do_access(1'b0, 3'd0, 32'h0000_0022, 32'h0, 32'h00FF_0000, 2, "b2b_2");
        idle_cycle();
    endtask

    task automatic test_timeout();
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h0000_0030; mem_rd_i = 32'hFFFF_FFFF; mem_ready_i = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk_i);
            n_cmp++;
            if (core_stall_o !== (k < 4) || bus_err_o !== (k == 4) || core_rd_o !== 32'h0) begin
                n_err++; $display("FAIL timeout k=%0d stall/err/rd got %b/%b/%h exp %b/%b/0", k, core_stall_o, bus_err_o, core_rd_o, k < 4, k == 4);
            end
            @(posedge clk_i); #1;
        end
        n_cmp++;
        if (dbg_state_o !== 1'b0) begin
            n_err++; $display("FAIL timeout_state got %b exp 0", dbg_state_o);
        end
        do_access(1'b0, 3'd2, 32'h0000_0034, 32'h0, 32'h5A5A_0001, 1, "after_timeout");
        // Ready in the very cycle the counter expires counts as completion.
        do_access(1'b0, 3'd2, 32'h0000_0038, 32'h0, 32'h0BAD_CAFE, 4, "ready_at_timeout");
        idle_cycle();
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h0000_0006;
        mem_rd_i = 32'h1234_5678;
        @(negedge clk_i);
        n_cmp++;
        if (mem_req_o !== 1'b0 || bus_err_o !== 1'b1 || core_stall_o !== 1'b0 || core_rd_o !== 32'h0) begin
            n_err++; $display("FAIL misalign req/err/stall/rd got %b/%b/%b/%h exp 0/1/0/0", mem_req_o, bus_err_o, core_stall_o, core_rd_o);
        end
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (dbg_state_o !== 1'b0 || bus_err_o !== 1'b0) begin
            n_err++; $display("FAIL misalign_after state/err got %b/%b exp 0/0", dbg_state_o, bus_err_o);
        end
        @(posedge clk_i); #1;
`else
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h0000_0006;
        @(negedge clk_i);
        n_cmp++;
        if (mem_addr_o !== 32'h0000_0004 || mem_be_o !== 4'b1111 || mem_req_o !== 1'b1) begin
            n_err++; $display("FAIL misalign_word addr/be/req got %h/%b/%b exp 00000004/1111/1", mem_addr_o, mem_be_o, mem_req_o);
        end
        @(posedge clk_i); #1;
        core_req_i = 1'b0; mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        do_access(1'b0, 3'd2, 32'h0000_0006, 32'h0, 32'h1234_5678, 1, "misalign_lw");
`endif
        idle_cycle();
    endtask

    task automatic test_reset_mid_wait();
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h0000_0040; mem_rd_i = 32'h7777_8888; mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({core_rd_o, core_stall_o, bus_err_o, mem_req_o, mem_we_o} !== 36'h0 || dbg_state_o !== 1'b0) begin
            n_err++; $display("FAIL midwait_reset got rd=%h s=%b e=%b r=%b w=%b st=%b exp all 0", core_rd_o, core_stall_o, bus_err_o, mem_req_o, mem_we_o, dbg_state_o);
        end
        n_cmp++;
        if (mem_be_o !== 4'h0 || mem_addr_o !== 32'h0 || mem_wd_o !== 32'h0) begin
            n_err++; $display("FAIL midwait_reset data got %b/%h/%h exp 0", mem_be_o, mem_addr_o, mem_wd_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        do_access(1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 2, "after_midwait_reset");
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_random();
        test_timeout();
        test_misalign();
        test_reset_mid_wait();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
